fft_bin_capture: RTL and testbench

FFT_BIN_CAPTURE -- requirements
Module: fft_bin_capture

---
 rtl/fft_bin_capture.sv | 182 ++++++++++++++++++
 tb/tb_fft_bin_capture.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bin_capture.sv
// fft_bin_capture: gathers the eight bins of one FFT frame, delivered one bin
// per in_valid strobe in index order 0..7, into shadow registers and publishes
// the whole frame to the y* outputs at once when bin 7 is accepted. Out-of-order
// bins, restarts and inter-bin gaps longer than TIMEOUT abort the frame.
module fft_bin_capture #(
    parameter int TIMEOUT = 64
) (
    input  logic        fastclk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_re,
    input  logic [15:0] in_im,
    input  logic [2:0]  in_index,
    output logic [15:0] y0,
    output logic [15:0] yr1,
    output logic [15:0] yi1,
    output logic [15:0] yr2,
    output logic [15:0] yi2,
    output logic [15:0] yr3,
    output logic [15:0] yi3,
    output logic [15:0] y4,
    output logic [15:0] yr5,
    output logic [15:0] yi5,
    output logic [15:0] yr6,
    output logic [15:0] yi6,
    output logic [15:0] yr7,
    output logic [15:0] yi7,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  frame_count
);

    typedef enum logic {
        SYNC    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Gap counter only has to count up to TIMEOUT-1: the abort fires on the
    // idle cycle that would bring it to TIMEOUT.
    localparam int GW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [2:0]    exp_q, exp_d;
    logic [GW-1:0] gap_q, gap_d;

    // Shadow copies of the frame under construction. Entry 7 is never used
    // because bin 7 goes straight to the outputs, and the imaginary entries
    // of bins 0 and 4 are never written.
    logic [15:0]   sh_re_q [0:7];
    logic [15:0]   sh_re_d [0:7];
    logic [15:0]   sh_im_q [0:7];
    logic [15:0]   sh_im_d [0:7];

    // Published frame, only ever replaced as a complete set.
    logic [15:0]   out_re_q [0:7];
    logic [15:0]   out_re_d [0:7];
    logic [15:0]   out_im_q [0:7];
    logic [15:0]   out_im_d [0:7];

    logic          frame_valid_q, frame_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    frame_count_q, frame_count_d;

    // Next-state logic: bin acceptance, frame publication, abort handling and
    // the inter-bin gap timer. An in_valid always wins over a timeout.
    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        gap_d         = gap_q;
        sh_re_d       = sh_re_q;
        sh_im_d       = sh_im_q;
        out_re_d      = out_re_q;
        out_im_d      = out_im_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;

        case (state_q)
            SYNC: begin
                gap_d = '0;
                exp_d = 3'd1;
                if (in_valid && (in_index == 3'd0)) begin
                    sh_re_d[0] = in_re;
                    state_d    = COLLECT;
                end
            end

            COLLECT: begin
                if (in_valid) begin
                    gap_d = '0;
                    if (in_index == exp_q) begin
                        if (exp_q == 3'd7) begin
                            out_re_d      = sh_re_q;
                            out_im_d      = sh_im_q;
                            out_re_d[7]   = in_re;
                            out_im_d[7]   = in_im;
                            frame_valid_d = 1'b1;
                            frame_count_d = frame_count_q + 8'd1;
                            exp_d         = 3'd1;
                            state_d       = SYNC;
                        end else begin
                            sh_re_d[in_index] = in_re;
                            if (in_index != 3'd4) begin
                                sh_im_d[in_index] = in_im;
                            end
                            exp_d = exp_q + 3'd1;
                        end
                    end else if (in_index == 3'd0) begin
                        frame_err_d = 1'b1;
                        sh_re_d[0]  = in_re;
                        exp_d       = 3'd1;
                    end else begin
                        frame_err_d = 1'b1;
                        exp_d       = 3'd1;
                        state_d     = SYNC;
                    end
                end else if (gap_q == GAP_LAST) begin
                    frame_err_d = 1'b1;
                    gap_d       = '0;
                    exp_d       = 3'd1;
                    state_d     = SYNC;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            default: begin
                state_d = SYNC;
                exp_d   = 3'd1;
                gap_d   = '0;
            end
        endcase
    end

    // State and data registers with synchronous reset taking priority over
    // any bin arriving in the same cycle.
    always_ff @(posedge fastclk) begin
        if (rst) begin
            state_q       <= SYNC;
            exp_q         <= 3'd1;
            gap_q         <= '0;
            sh_re_q       <= '{default: 16'h0000};
            sh_im_q       <= '{default: 16'h0000};
            out_re_q      <= '{default: 16'h0000};
            out_im_q      <= '{default: 16'h0000};
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            gap_q         <= gap_d;
            sh_re_q       <= sh_re_d;
            sh_im_q       <= sh_im_d;
            out_re_q      <= out_re_d;
            out_im_q      <= out_im_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign y0          = out_re_q[0];
    assign yr1         = out_re_q[1];
    assign yi1         = out_im_q[1];
    assign yr2         = out_re_q[2];
    assign yi2         = out_im_q[2];
    assign yr3         = out_re_q[3];
    assign yi3         = out_im_q[3];
    assign y4          = out_re_q[4];
    assign yr5         = out_re_q[5];
    assign yi5         = out_im_q[5];
    assign yr6         = out_re_q[6];
    assign yi6         = out_im_q[6];
    assign yr7         = out_re_q[7];
    assign yi7         = out_im_q[7];
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_bin_capture.sv
// tb_fft_bin_capture: directed stimulus for fft_bin_capture with hand-computed
// expectations. Inputs change on the falling edge; outputs are read on the
// falling edge after the rising edge that consumed the inputs.
module tb_fft_bin_capture;

    logic        fastclk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic [2:0]  in_index;
    logic [15:0] y0, yr1, yi1, yr2, yi2, yr3, yi3, y4;
    logic [15:0] yr5, yi5, yr6, yi6, yr7, yi7;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  frame_count;

    int compared      = 0;
    int mismatched    = 0;
    int fv_count      = 0;
    int err_count     = 0;
    int overlap_count = 0;
    int fv_snap       = 0;
    int err_snap      = 0;

    fft_bin_capture #(.TIMEOUT(64)) dut (
        .fastclk     (fastclk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_index    (in_index),
        .y0          (y0),
        .yr1         (yr1),
        .yi1         (yi1),
        .yr2         (yr2),
        .yi2         (yi2),
        .yr3         (yr3),
        .yi3         (yi3),
        .y4          (y4),
        .yr5         (yr5),
        .yi5         (yi5),
        .yr6         (yr6),
        .yi6         (yi6),
        .yr7         (yr7),
        .yi7         (yi7),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    // Free-running 10-unit clock.
    initial begin
        fastclk = 1'b0;
        forever #5 fastclk = ~fastclk;
    end

    // Tally pulses seen during the previous cycle; values are stable here.
    always @(posedge fastclk) begin
        if (frame_valid) fv_count++;
        if (frame_err) err_count++;
        if (frame_valid && frame_err) overlap_count++;
    end

    // Drive one cycle of inputs (called on a falling edge) and return on the
    // next falling edge, when the registered response is visible.
    task automatic applyStimulus(input logic v, input logic [2:0] idx,
                                 input logic [15:0] re, input logic [15:0] im);
        in_valid = v;
        in_index = idx;
        in_re    = re;
        in_im    = im;
        @(negedge fastclk);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 3'd0, 16'h0000, 16'h0000);
    endtask

    task automatic sendBin(input logic [2:0] idx, input logic [15:0] re, input logic [15:0] im);
        applyStimulus(1'b1, idx, re, im);
    endtask

    // Clean frame whose bin i carries re_base+i / im_base+i.
    task automatic sendFrame(input logic [15:0] re_base, input logic [15:0] im_base);
        for (int i = 0; i < 8; i++) sendBin(3'(i), re_base + 16'(i), im_base + 16'(i));
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic takeSnap();
        fv_snap  = fv_count;
        err_snap = err_count;
    endtask

    // Directed sequence.
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_index = 3'd0;
        in_re    = 16'h0000;
        in_im    = 16'h0000;
        @(negedge fastclk);
        @(negedge fastclk);

        // Reset wins over a bin 0 in the same cycle.
        sendBin(3'd0, 16'hDEAD, 16'hBEEF);
        checkOutput("rst_y0", y0, 16'h0000);
        checkOutput("rst_yi7", yi7, 16'h0000);
        checkOutput("rst_fc", frame_count, 8'd0);
        checkOutput("rst_fv", frame_valid, 1'b0);
        checkOutput("rst_fe", frame_err, 1'b0);
        rst = 1'b0;
        idleCycles(1);
        checkOutput("rst_idle_fv", frame_valid, 1'b0);

        // Frame with bins 52 cycles apart.
        for (int i = 0; i < 7; i++) begin
            sendBin(3'(i), 16'h0100 + 16'(i), 16'h0200 + 16'(i));
            idleCycles(51);
        end
        checkOutput("partial_y0", y0, 16'h0000);
        checkOutput("partial_fe", frame_err, 1'b0);
        sendBin(3'd7, 16'h0107, 16'h0207);
        checkOutput("f1_fv", frame_valid, 1'b1);
        checkOutput("f1_y0", y0, 16'h0100);
        checkOutput("f1_yr3", yr3, 16'h0103);
        checkOutput("f1_yi3", yi3, 16'h0203);
        checkOutput("f1_y4", y4, 16'h0104);
        checkOutput("f1_yi7", yi7, 16'h0207);
        checkOutput("f1_fc", frame_count, 8'd1);
        idleCycles(1);
        checkOutput("f1_fv_drop", frame_valid, 1'b0);
        checkOutput("f1_hold_y0", y0, 16'h0100);

        // Stream joined mid-frame: 5,6,7 ignored silently.
        takeSnap();
        sendBin(3'd5, 16'h0F0F, 16'h0F0F);
        sendBin(3'd6, 16'h0F0F, 16'h0F0F);
        sendBin(3'd7, 16'h0F0F, 16'h0F0F);
        checkOutput("join_fe", frame_err, 1'b0);
        sendFrame(16'h1100, 16'h1200);
        checkOutput("join_fv", frame_valid, 1'b1);
        checkOutput("join_yr5", yr5, 16'h1105);
        checkOutput("join_yi6", yi6, 16'h1206);
        checkOutput("join_fc", frame_count, 8'd2);
        idleCycles(1);
        checkOutput("join_errs", err_count - err_snap, 0);
        checkOutput("join_fvs", fv_count - fv_snap, 1);

        // Out-of-order bin aborts; published frame untouched.
        takeSnap();
        sendBin(3'd0, 16'h2200, 16'h2300);
        sendBin(3'd1, 16'h2201, 16'h2301);
        sendBin(3'd2, 16'h2202, 16'h2302);
        sendBin(3'd5, 16'h2205, 16'h2305);
        checkOutput("ooo_fe", frame_err, 1'b1);
        checkOutput("ooo_fv", frame_valid, 1'b0);
        checkOutput("ooo_y0", y0, 16'h1100);
        checkOutput("ooo_yi1", yi1, 16'h1201);
        checkOutput("ooo_fc", frame_count, 8'd2);
        idleCycles(1);
        checkOutput("ooo_fe_drop", frame_err, 1'b0);
        sendFrame(16'h3300, 16'h3400);
        checkOutput("ooo_next_yr7", yr7, 16'h3307);
        checkOutput("ooo_next_yi1", yi1, 16'h3401);
        checkOutput("ooo_next_fc", frame_count, 8'd3);
        idleCycles(1);
        checkOutput("ooo_errs", err_count - err_snap, 1);
        checkOutput("ooo_fvs", fv_count - fv_snap, 1);

        // Gap of 64 idle cycles times out; late bins are then ignored.
        takeSnap();
        sendBin(3'd0, 16'h4400, 16'h4500);
        sendBin(3'd1, 16'h4401, 16'h4501);
        idleCycles(63);
        checkOutput("to_63_fe", frame_err, 1'b0);
        idleCycles(1);
        checkOutput("to_64_fe", frame_err, 1'b1);
        idleCycles(1);
        checkOutput("to_fe_drop", frame_err, 1'b0);
        for (int i = 2; i < 8; i++) sendBin(3'(i), 16'h4400 + 16'(i), 16'h4500 + 16'(i));
        idleCycles(1);
        checkOutput("to_fvs", fv_count - fv_snap, 0);
        checkOutput("to_errs", err_count - err_snap, 1);
        checkOutput("to_fc", frame_count, 8'd3);
        checkOutput("to_y0", y0, 16'h3300);

        // Gap of 63: next bin lands on the timeout cycle and wins.
        takeSnap();
        sendBin(3'd0, 16'h5500, 16'h5600);
        sendBin(3'd1, 16'h5501, 16'h5601);
        idleCycles(63);
        for (int i = 2; i < 8; i++) sendBin(3'(i), 16'h5500 + 16'(i), 16'h5600 + 16'(i));
        checkOutput("gap63_fv", frame_valid, 1'b1);
        checkOutput("gap63_y0", y0, 16'h5500);
        checkOutput("gap63_yr2", yr2, 16'h5502);
        checkOutput("gap63_yi2", yi2, 16'h5602);
        checkOutput("gap63_fc", frame_count, 8'd4);
        idleCycles(1);
        checkOutput("gap63_errs", err_count - err_snap, 0);

        // Restart with a new bin 0 mid-frame.
        takeSnap();
        sendBin(3'd0, 16'h6000, 16'h6100);
        sendBin(3'd1, 16'h6001, 16'h6101);
        sendBin(3'd2, 16'h6002, 16'h6102);
        sendBin(3'd0, 16'h6600, 16'h6700);
        checkOutput("rs_fe", frame_err, 1'b1);
        for (int i = 1; i < 8; i++) sendBin(3'(i), 16'h6600 + 16'(i), 16'h6700 + 16'(i));
        checkOutput("rs_fv", frame_valid, 1'b1);
        checkOutput("rs_fe_clear", frame_err, 1'b0);
        checkOutput("rs_y0", y0, 16'h6600);
        checkOutput("rs_yr1", yr1, 16'h6601);
        checkOutput("rs_fc", frame_count, 8'd5);
        idleCycles(1);
        checkOutput("rs_errs", err_count - err_snap, 1);
        checkOutput("rs_fvs", fv_count - fv_snap, 1);

        // Reset mid-frame with in_valid high.
        takeSnap();
        for (int i = 0; i < 5; i++) sendBin(3'(i), 16'h7700 + 16'(i), 16'h7800 + 16'(i));
        rst = 1'b1;
        sendBin(3'd5, 16'h7705, 16'h7805);
        checkOutput("mrst_y0", y0, 16'h0000);
        checkOutput("mrst_yr1", yr1, 16'h0000);
        checkOutput("mrst_yi3", yi3, 16'h0000);
        checkOutput("mrst_y4", y4, 16'h0000);
        checkOutput("mrst_yr7", yr7, 16'h0000);
        checkOutput("mrst_fc", frame_count, 8'd0);
        checkOutput("mrst_fe", frame_err, 1'b0);
        checkOutput("mrst_fv", frame_valid, 1'b0);
        rst = 1'b0;
        sendBin(3'd6, 16'h7706, 16'h7806);
        sendBin(3'd7, 16'h7707, 16'h7807);
        sendFrame(16'h8800, 16'h8900);
        checkOutput("mrst_next_fc", frame_count, 8'd1);
        checkOutput("mrst_next_y0", y0, 16'h8800);
        checkOutput("mrst_next_yr6", yr6, 16'h8806);
        checkOutput("mrst_next_yi7", yi7, 16'h8907);
        idleCycles(1);
        checkOutput("mrst_errs", err_count - err_snap, 0);
        checkOutput("mrst_fvs", fv_count - fv_snap, 1);

        // 256 back-to-back frames wrap the counter to 0.
        rst = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        idleCycles(1);
        takeSnap();
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 8; i++) begin
                sendBin(3'(i), 16'hA000 + 16'(f * 8 + i), ~(16'hA000 + 16'(f * 8 + i)));
            end
            if (f == 254) checkOutput("wrap_fc255", frame_count, 8'd255);
        end
        checkOutput("wrap_fc0", frame_count, 8'd0);
        checkOutput("wrap_fv", frame_valid, 1'b1);
        checkOutput("wrap_y0", y0, 16'hA7F8);
        checkOutput("wrap_yi7", yi7, 16'h5800);
        idleCycles(1);
        checkOutput("wrap_fvs", fv_count - fv_snap, 256);
        checkOutput("wrap_errs", err_count - err_snap, 0);
        checkOutput("no_overlap", overlap_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
